// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer.
// Holds the state encoding, opcode values, ALU operation codes and ALU-B mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_WB_R,
    S_BRANCH,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [1:0] {
    CLS_MEM,
    CLS_BRANCH,
    CLS_RTYPE
  } op_class_e;

endpackage

// File: rtl/mc_ctrl_fsm_alu_decode.sv
// Combinational ALU operation decode from instruction class and funct fields.
// Flags R-type encodings outside the supported subset as illegal.
module alu_decode
  import mc_ctrl_pkg::*;
(
  input  op_class_e   cls,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output alu_op_e     alu_ctrl,
  output logic        illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (cls)
      CLS_MEM:    alu_ctrl = ALU_ADD;
      CLS_BRANCH: alu_ctrl = ALU_SUB;
      CLS_RTYPE: begin
        if (funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
        case (funct3)
          3'b000:  alu_ctrl = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1; // funct3=011 (sltu) is outside the subset
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback and drives the datapath enables and the shared memory handshake.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | classify opcode, precompute branch target
// MEM_ADDR   | rs1+imm effective address
// MEM_RD     | load data read, waits on mem_ready
// MEM_WB     | load data to register file, retire
// MEM_WR     | store write, waits on mem_ready, retire
// EXEC_R     | R-type ALU operation
// WB_R       | ALU result to register file, retire
// BRANCH     | rs1-rs2 compare, take branch on zero, retire
// TRAP       | illegal instruction, held until reset
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPLEN = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPLEN-1:0] op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctrl,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic             trap
);

  state_e    state, state_nxt;
  op_class_e cls;
  alu_op_e   dec_ctrl;
  logic      dec_illegal;

  always_comb begin
    cls = CLS_MEM;
    if (op == OPLEN'(OP_R))           cls = CLS_RTYPE;
    else if (op == OPLEN'(OP_BRANCH)) cls = CLS_BRANCH;
  end

  alu_decode u_alu_decode (
    .cls      (cls),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RS2;
    alu_ctrl   = ALU_AND;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_ADD;
        if (op == OPLEN'(OP_R))
          state_nxt = dec_illegal ? S_TRAP : S_EXEC_R;
        else if (op == OPLEN'(OP_LOAD) || op == OPLEN'(OP_STORE))
          state_nxt = S_MEM_ADDR;
        else if (op == OPLEN'(OP_BRANCH))
          state_nxt = S_BRANCH;
        else
          state_nxt = S_TRAP;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = dec_ctrl;
        state_nxt = (op == OPLEN'(OP_LOAD)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_ctrl;
        state_nxt = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_ctrl;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
    // Reset forces every output low at once, so an aborted writeback never lands.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RS2;
      alu_ctrl   = ALU_AND;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
      trap       = 1'b0;
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the RV32I subset core. It steps each instruction through fetch, decode, execute, memory and writeback states and drives the per-state datapath enables. It issues the memory handshake and decodes the ALU operation from opcode/funct fields. It sits between the instruction register / shared memory port and the register file, ALU and PC datapath.

## Interface
- `OPLEN`, 7: opcode width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in OPLEN: opcode field from the instruction register.
- `funct3` in 3: funct3 field.
- `funct7` in 7: funct7 field.
- `zero` in 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `mem_req` out 1: memory access request, held until `mem_ready`.
- `mem_we` out 1: write qualifier for `mem_req`.
- `iord` out 1: address select, 0=PC, 1=ALUOut.
- `ir_write` out 1: load instruction register.
- `pc_write` out 1: load PC.
- `pc_src` out 1: PC source, 0=ALU result (PC+4), 1=ALUOut (branch target).
- `alu_src_a` out 1: ALU A select, 0=PC, 1=rs1.
- `alu_src_b` out 2: ALU B select, 00=rs2, 01=const 4, 10=imm.
- `alu_ctrl` out 4: ALU operation code.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 1: writeback source, 1=memory data, 0=ALUOut.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `trap` out 1: sticky illegal-opcode flag.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, BRANCH, TRAP.
- FETCH:
  - `mem_req`=1, `iord`=0, ALU computes PC+4 (`alu_src_a`=0, `alu_src_b`=01, ADD).
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
  - Without `mem_ready`: stay in FETCH.
- DECODE: ALU computes the branch target (`alu_src_a`=0, `alu_src_b`=10, ADD). Next state by opcode:
  - 0110011 → EXEC_R
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - anything else → TRAP
- MEM_ADDR: rs1+imm (ADD). Loads go to MEM_RD, stores to MEM_WR.
- MEM_RD: `mem_req`=1, `iord`=1. On `mem_ready` go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `retire`=1, then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready`: `retire`=1, then FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct decode, then WB_R.
- WB_R: `reg_write`=1, `mem_to_reg`=0, `retire`=1, then FETCH.
- BRANCH: SUB of rs1 and rs2. If `zero`, assert `pc_write` with `pc_src`=1. Always `retire`=1, then FETCH.
- TRAP: all enables 0, `trap`=1. Only `rst_n` exits.
- ALU codes: AND 0000, OR 0001, ADD 0010, SLL 0011, XOR 0100, SRL 0101, SUB 0110, SLT 0111.
- R-type decode by funct3:
  - 000: ADD, or SUB when funct7=0100000.
  - 001: SLL
  - 010: SLT
  - 100: XOR
  - 101: SRL
  - 110: OR
  - 111: AND
- Any funct7 other than 0000000/0100000 on R-type → TRAP, detected in DECODE.
- Outputs are Moore functions of state, except `ir_write`, `pc_write` and `retire`, which are additionally qualified by `mem_ready` or `zero` in the same cycle.

## Timing
- Reset: state=FETCH and `trap`=0. `mem_req` is asserted during reset, gated to 0 while `rst_n`=0; all other outputs are 0.
- Zero-wait-state latency (cycles from FETCH entry to `retire`):
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
- Each extra cycle with `mem_ready` low adds one cycle in the waiting state.
- `mem_ready` is ignored whenever `mem_req`=0.
- `retire` is never high on two consecutive cycles.
- Reset asserted mid-instruction aborts immediately. No partial writeback; `reg_write` drops asynchronously.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum
  - opcode constants (OP_R, OP_LOAD, OP_STORE, OP_BRANCH)
  - `alu_op_e` with the codes above
  - the `alu_src_b` select constants
- Sub-module `alu_decode`: combinational. Takes a class (mem/branch/rtype), funct3 and funct7; returns `alu_ctrl` and an illegal flag.

## Test plan
- add, op=0110011, f3=000, f7=0, `mem_ready` tied 1:
  - `alu_ctrl`=0010 in EXEC_R
  - `reg_write`=1 in the 4th cycle, with `retire`
- sub (f7=0100000) → `alu_ctrl`=0110. sll (f3=001) → 0011. and (f3=111) → 0000.
- lw with `mem_ready` low for 3 cycles in MEM_RD:
  - `mem_req`=1 and `iord`=1 held throughout
  - `mem_to_reg`=1 and `reg_write`=1 exactly once
  - `retire` at cycle 8
- sw: `mem_we`=1 only in MEM_WR, `reg_write` never 1, `retire` at cycle 4.
- beq:
  - `zero`=1 → `pc_write`=1 with `pc_src`=1 in cycle 3
  - `zero`=0 → `pc_write`=0 in cycle 3
- Illegal input: op=1111111, or R-type with f7=0000001:
  - TRAP entered after DECODE and `trap` stays 1
  - `rst_n` pulse low returns to FETCH with `trap`=0
